// File: rtl/dbg_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbg_mem_pkg
// Purpose  : Shared state encodings and constants for the debug memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dbg_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] c_dead_beef   = 32'hDEAD_BEEF;
  localparam logic [31:0] c_bounds_mask = 32'hFFFF_0000;

  function automatic logic out_of_bounds(input logic [31:0] addr);
    return (addr & c_bounds_mask) != 32'h0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : dbg_req_latch
// Purpose  : Captures one debug request and holds it until the arbiter retires it.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_req_latch
  import dbg_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_idle,
  input  logic        i_clear,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_imem,
  output logic        o_pend,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_we,
  output logic        o_imem
);

  logic        r_pend;
  logic        r_we;
  logic        r_imem;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_accept;

  assign w_accept = (i_we | i_re) & ~r_pend & i_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_imem  <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (i_clear) begin
      r_pend <= 1'b0;
    end else if (w_accept) begin
      r_pend  <= 1'b1;
      r_we    <= i_we;
      r_imem  <= i_imem;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  // A fresh request is visible the cycle it arrives so arbitration adds no extra cycle.
  assign o_pend  = r_pend | w_accept;
  assign o_we    = r_pend ? r_we    : i_we;
  assign o_imem  = r_pend ? r_imem  : i_imem;
  assign o_addr  = r_pend ? r_addr  : i_addr;
  assign o_wdata = r_pend ? r_wdata : i_wdata;

endmodule
`default_nettype wire

// File: rtl/dbg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dbg_mem_arbiter
// Purpose  : Shares dmem between CPU and debug monitor; debug path into imem.
//            Optional DBG_MEM_BOUNDS_EN rejects debug dmem accesses above 64 KiB.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_mem_arbiter
  import dbg_mem_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        cpu_halted,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_we,
  input  logic        dbg_re,
  input  logic        dbg_imem_p_dmem_n,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        dbg_wdone,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        imem_we,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  input  logic [31:0] dmem_rdata
);

  localparam int          c_sw         = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_sw-1:0] c_max_wait = c_sw'(MAX_WAIT);
  localparam logic [1:0]  c_lat_init   = 2'(RD_LAT - 1);

  state_t            r_state;
  logic [c_sw-1:0]   r_starve;
  logic [1:0]        r_lat;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_wdone;

  logic              w_pend;
  logic              w_req_we;
  logic              w_req_imem;
  logic [31:0]       w_req_addr;
  logic [31:0]       w_req_wdata;
  logic              w_oob;
  logic              w_grant;
  logic              w_dbg_dmem;
  logic              w_dbg_imem;
  logic              w_issue;

  dbg_req_latch u_req_latch (
    .clk     (clk),
    .rst     (rst_p),
    .i_idle  (r_state == S_IDLE),
    .i_clear (r_state == S_DONE),
    .i_we    (dbg_we),
    .i_re    (dbg_re),
    .i_addr  (dbg_addr),
    .i_wdata (dbg_wdata),
    .i_imem  (dbg_imem_p_dmem_n),
    .o_pend  (w_pend),
    .o_addr  (w_req_addr),
    .o_wdata (w_req_wdata),
    .o_we    (w_req_we),
    .o_imem  (w_req_imem)
  );

`ifdef DBG_MEM_BOUNDS_EN
  assign w_oob = ~w_req_imem & out_of_bounds(w_req_addr);
`else
  assign w_oob = 1'b0;
`endif

  // Rejected and imem requests never touch dmem, so they need no CPU arbitration.
  assign w_grant = w_pend & (w_req_imem | w_oob | cpu_halted | ~(cpu_we | cpu_re) |
                             (r_starve == c_max_wait));

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
      r_lat    <= 2'd0;
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_starve <= '0;
            if (w_oob) begin
              r_state <= S_DONE;
              if (w_req_we) begin
                r_wdone <= 1'b1;
              end else begin
                r_rvalid <= 1'b1;
                r_rdata  <= c_dead_beef;
              end
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (w_pend && (r_starve != c_max_wait)) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_req_we) begin
            r_state <= S_DONE;
            r_wdone <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_lat   <= c_lat_init;
          end
        end
        S_WAIT: begin
          if (r_lat == 2'd0) begin
            r_state  <= S_DONE;
            r_rvalid <= 1'b1;
            r_rdata  <= w_req_imem ? imem_rdata : dmem_rdata;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue    = (r_state == S_ISSUE);
  assign w_dbg_dmem = ((r_state == S_ISSUE) || (r_state == S_WAIT)) & ~w_req_imem;
  assign w_dbg_imem = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &  w_req_imem;

  // Combinational paths are forced low during reset so every output reads 0.
  always_comb begin
    cpu_rdata  = 32'h0;
    cpu_stall  = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    imem_addr  = 32'h0;
    imem_wdata = 32'h0;
    imem_we    = 1'b0;
    if (!rst_p) begin
      cpu_rdata = dmem_rdata;
      cpu_stall = w_dbg_dmem;
      if (w_dbg_dmem) begin
        dmem_addr  = w_req_addr;
        dmem_wdata = w_req_wdata;
        dmem_we    = w_issue &  w_req_we;
        dmem_re    = w_issue & ~w_req_we;
      end else begin
        dmem_addr  = cpu_addr;
        dmem_wdata = cpu_wdata;
        dmem_we    = cpu_we;
        dmem_re    = cpu_re;
      end
      if (w_dbg_imem) begin
        imem_addr  = w_req_addr;
        imem_wdata = w_req_wdata;
        imem_we    = w_issue & w_req_we;
      end
    end
  end

  assign dbg_rdata  = r_rdata;
  assign dbg_rvalid = r_rvalid;
  assign dbg_wdone  = r_wdone;

endmodule
`default_nettype wire
